// File: rtl/present_pkg.sv
// Shared types and constants for the bonus present: state encoding, present kinds, LFSR taps.
package present_pkg;

   typedef enum logic [1:0] {IDLE, FALLING, LANDED} present_st_t;

   localparam logic [1:0] PRESENT_LIFE       = 2'b00;
   localparam logic [1:0] PRESENT_SUPER_ROPE = 2'b01;
   localparam logic [1:0] PRESENT_SPEED      = 2'b10;
   localparam logic [1:0] PRESENT_IMMORTAL   = 2'b11;

   // Fibonacci taps 16,14,13,11 (maximal length, never reaches zero from a non-zero seed)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/present_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exposes only the bits used for spawn position and type.
module present_lfsr
   import present_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       resetN,
   output logic [1:0] value_hi,
   output logic [8:0] value_lo
);

   logic [15:0] state;
   logic        feedback;

   assign feedback = ^(state & LFSR_TAPS);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= SEED;
      else         state <= {state[14:0], feedback};
   end

   assign value_hi = state[15:14];
   assign value_lo = state[8:0];

endmodule

// File: rtl/present_dropper.sv
// Spawns, animates and retires the single falling bonus present.
// Optional PRESENT_GRAVITY_EN: accelerating fall (velocity 1 up to FALL_SPEED) instead of constant speed.
//
// state   | meaning
// IDLE    | no present on screen; waits for presentDrop while presentsVisible
// FALLING | present moving down by speed on each startOfFrame
// LANDED  | present resting on the floor; retires after LAND_SECONDS secClk pulses
module present_dropper
   import present_pkg::*;
#(
   parameter int          X_MIN        = 64,
   parameter int          SPAWN_Y      = 0,
   parameter int          FLOOR_Y      = 447,
   parameter int          FALL_SPEED   = 2,
   parameter int          LAND_SECONDS = 3,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        secClk,
   input  logic        presentDrop,
   input  logic        presentsVisible,
   input  logic        col_present,
   output logic [10:0] presentX,
   output logic [10:0] presentY,
   output logic [1:0]  presentType,
   output logic        presentActive,
   output logic        presentTaken
);

   present_st_t state_q, state_d;
   logic [10:0] x_d, y_d;
   logic [1:0]  type_d;
   logic [7:0]  timer_q, timer_d;
   logic        taken_d;
   logic [1:0]  lfsr_hi;
   logic [8:0]  lfsr_lo;
   logic [3:0]  speed;
   logic [11:0] y_sum;
   logic        landing;

   present_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk      (clk),
      .resetN   (resetN),
      .value_hi (lfsr_hi),
      .value_lo (lfsr_lo)
   );

`ifdef PRESENT_GRAVITY_EN
   logic [3:0] vel_q, vel_d;
   assign speed = vel_q;
`else
   assign speed = 4'(FALL_SPEED);
`endif

   // 12-bit sum so a position near the top of the 11-bit range cannot wrap past the floor
   assign y_sum   = {1'b0, presentY} + {8'd0, speed};
   assign landing = (y_sum >= 12'(FLOOR_Y));

   always_comb begin
      state_d = state_q;
      x_d     = presentX;
      y_d     = presentY;
      type_d  = presentType;
      timer_d = timer_q;
      taken_d = 1'b0;
`ifdef PRESENT_GRAVITY_EN
      vel_d   = vel_q;
`endif
      if (!presentsVisible) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (presentDrop) begin
                  state_d = FALLING;
                  x_d     = 11'(X_MIN) + {2'b00, lfsr_lo};
                  y_d     = 11'(SPAWN_Y);
                  type_d  = lfsr_hi;
`ifdef PRESENT_GRAVITY_EN
                  vel_d   = 4'd1;
`endif
               end
            end
            FALLING: begin
               if (col_present) begin
                  state_d = IDLE;
                  taken_d = 1'b1;
               end else if (startOfFrame) begin
`ifdef PRESENT_GRAVITY_EN
                  if (vel_q < 4'(FALL_SPEED)) vel_d = vel_q + 4'd1;
`endif
                  if (landing) begin
                     y_d     = 11'(FLOOR_Y);
                     timer_d = 8'(LAND_SECONDS);
                     state_d = LANDED;
                  end else begin
                     y_d = y_sum[10:0];
                  end
               end
            end
            LANDED: begin
               if (col_present) begin
                  state_d = IDLE;
                  taken_d = 1'b1;
               end else if (secClk) begin
                  if (timer_q != 8'd0) timer_d = timer_q - 8'd1;
                  // a zero timer (LAND_SECONDS=0) retires on the first second as well
                  if (timer_q <= 8'd1) state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q       <= IDLE;
         presentX      <= '0;
         presentY      <= '0;
         presentType   <= PRESENT_LIFE;
         presentActive <= 1'b0;
         presentTaken  <= 1'b0;
         timer_q       <= '0;
`ifdef PRESENT_GRAVITY_EN
         vel_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         presentX      <= x_d;
         presentY      <= y_d;
         presentType   <= type_d;
         presentActive <= (state_d != IDLE);
         presentTaken  <= taken_d;
         timer_q       <= timer_d;
`ifdef PRESENT_GRAVITY_EN
         vel_q         <= vel_d;
`endif
      end
   end

endmodule

// File: doc/present_dropper.md
Name: present_dropper

Overview:
Spawns, animates and retires the single falling bonus present. It is the responder to the game FSM's presentDrop request and supplies the presentType that the FSM reads when col_present fires. Outputs feed the present drawing object and the present/player collision detector. Only one present exists at a time.

Parameters:
X_MIN, 64, leftmost spawn X in pixels; spawn X = X_MIN + lfsr[8:0], range 64..575.
SPAWN_Y, 0, Y coordinate at spawn.
FLOOR_Y, 447, resting Y (479 minus 32-pixel sprite height).
FALL_SPEED, 2, pixels per frame in constant-speed mode; also the velocity cap in gravity mode.
LAND_SECONDS, 3, number of secClk pulses a landed present persists.
LFSR_SEED, 16'hACE1, non-zero LFSR reset value.

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per video frame
secClk  in  1  one-cycle pulse per second
presentDrop  in  1  one-cycle spawn request from the game FSM
presentsVisible  in  1  high only in play mode; low forces retire
col_present  in  1  player/present collision, level
presentX  out  11  present top-left X
presentY  out  11  present top-left Y
presentType  out  2  00 life, 01 super rope, 10 speed, 11 immortal
presentActive  out  1  a present exists; drawing enable
presentTaken  out  1  one-cycle pulse when the present is collected

Behaviour:
- Reset is resetN, asynchronous, active-low; clock is clk. On reset: state IDLE, presentX=0, presentY=0, presentType=00, presentActive=0, presentTaken=0, lfsr=LFSR_SEED, landTimer=0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every clk cycle, so the sequence depends on when presentDrop arrives. It never reaches zero.
- States: IDLE, FALLING, LANDED. All outputs are registered. presentActive=1 exactly when the state is not IDLE.
- IDLE -> FALLING: on presentDrop=1 and presentsVisible=1. On the next edge, the block latches:
  - presentX = X_MIN + lfsr[8:0]
  - presentY = SPAWN_Y
  - presentType = lfsr[15:14]
- FALLING: on each startOfFrame, presentY += speed.
  - If presentY + speed >= FLOOR_Y, presentY = FLOOR_Y, landTimer = LAND_SECONDS, and the state goes to LANDED.
  - The comparison is done in 12 bits to avoid wrap.
- LANDED: on each secClk, landTimer decrements. On a secClk while landTimer==1, the state goes to IDLE. If LAND_SECONDS=0, the present retires on the first secClk.
- Collection: col_present=1 in FALLING or LANDED moves the state to IDLE next cycle and pulses presentTaken for exactly one cycle.
  - Collection has priority over landing and timeout in the same cycle.
  - col_present in IDLE is ignored and produces no pulse.
- presentType, presentX and presentY hold their values after retiring until the next spawn. This lets the FSM sample presentType in the collision cycle and the cycle after.
- presentDrop while FALLING or LANDED is ignored: no respawn and no queuing.
- presentsVisible=0 in any state forces IDLE on the next edge with no presentTaken pulse. presentDrop is ignored while presentsVisible=0.
- Simultaneous startOfFrame and secClk: each is applied to the state it concerns, and no pulse is lost.

Optional Feature:
PRESENT_GRAVITY_EN
- Defined: a 4-bit velocity register is set to 1 at spawn. It increments on every startOfFrame while FALLING, saturating at FALL_SPEED. presentY += velocity, where the add uses the value before the increment.
- Undefined: the velocity register is not built, and the speed is the constant FALL_SPEED.

Decomposition:
- Package present_pkg holds:
  - typedef enum logic [1:0] {IDLE, FALLING, LANDED} present_st_t
  - constants PRESENT_LIFE=2'b00, PRESENT_SUPER_ROPE=2'b01, PRESENT_SPEED=2'b10, PRESENT_IMMORTAL=2'b11
  - LFSR tap mask 16'hB400
- The game FSM imports the same type constants.
- One sub-module, present_lfsr: a free-running 16-bit LFSR with a seed parameter.

Test Plan:
- Reset mid-fall (presentY=100) -> all outputs 0 immediately; LFSR restarts at 16'hACE1.
- Spawn: presentsVisible=1, presentDrop pulse -> next cycle presentActive=1, presentY=0, presentX in 64..575, presentType=lfsr[15:14] at the request edge.
- Fall to floor, FALL_SPEED=2: 224 startOfFrame pulses -> presentY=447 and state LANDED; 3 secClk pulses -> presentActive=0; presentType unchanged.
- Collection: col_present=1 at presentY=200, coincident with startOfFrame -> next cycle presentActive=0, presentTaken high for exactly 1 cycle; col_present held 5 cycles -> still a single pulse.
- presentDrop while FALLING -> presentX, presentY and presentType are not reset. Then presentsVisible=0 -> IDLE next cycle with no presentTaken pulse; presentDrop with presentsVisible=0 -> stays IDLE.
- PRESENT_GRAVITY_EN defined: Y sequence over the first frames is 0, 1, 3, 5, 7, ... with velocity capped at 2.
